// File: rtl/fp8_tile_stager.sv
// Operand staging and result drain around the combinational FP8 4x4 tensor core.
// A/B/C rows are loaded into holding registers, held stable while the core settles, then D is captured and streamed out row by row.
module fp8_tile_stager #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_sel,
    input  logic [1:0]   in_row,
    input  logic [63:0]  in_data,
    input  logic         start,
    output logic [127:0] a_flat,
    output logic [127:0] b_flat,
    output logic [255:0] c_flat,
    input  logic [255:0] d_flat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_row,
    output logic [63:0]  out_data,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0]   state_reg;
    logic [11:0]  mask_reg;
    logic [3:0]   settle_cnt_reg;
    logic [1:0]   out_row_reg;
    logic [255:0] d_reg;
    logic         done_reg;
    logic         err_reg;

    logic         beat_fire;
    logic [11:0]  beat_bit;
    logic [11:0]  mask_next;
    logic         start_accept;
    logic         start_reject;

    assign in_ready  = (state_reg == ST_LOAD);
    assign beat_fire = in_valid && in_ready;

    // Mask bit index is {sel,row}: A rows 0..3, B rows 4..7, C rows 8..11.
    always_comb begin
        beat_bit = '0;
        if (beat_fire && in_sel != 2'd3)
            beat_bit[{in_sel, in_row}] = 1'b1;
    end

    assign mask_next    = mask_reg | beat_bit;
    assign start_accept = (state_reg == ST_LOAD) && start && (&mask_next);
    assign start_reject = (state_reg == ST_LOAD) && start && !(&mask_next);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rows
            logic [31:0] a_row_reg;
            logic [31:0] b_row_reg;
            logic [63:0] c_row_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_row_reg <= '0;
                    b_row_reg <= '0;
                    c_row_reg <= '0;
                end else if (beat_fire && in_row == 2'(gi)) begin
                    if (in_sel == 2'd0) a_row_reg <= in_data[31:0];
                    if (in_sel == 2'd1) b_row_reg <= in_data[31:0];
                    if (in_sel == 2'd2) c_row_reg <= in_data;
                end
            end

            assign a_flat[32*gi +: 32] = a_row_reg;
            assign b_flat[32*gi +: 32] = b_row_reg;
            assign c_flat[64*gi +: 64] = c_row_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_LOAD;
            mask_reg       <= '0;
            settle_cnt_reg <= '0;
            out_row_reg    <= '0;
            d_reg          <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= (beat_fire && in_sel == 2'd3) || start_reject;
            case (state_reg)
                ST_LOAD: begin
                    mask_reg <= mask_next;
                    if (start_accept) begin
                        state_reg      <= ST_SETTLE;
                        settle_cnt_reg <= '0;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt_reg <= settle_cnt_reg + 4'd1;
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        d_reg       <= d_flat;
                        state_reg   <= ST_DRAIN;
                        out_row_reg <= '0;
                    end
                end
                ST_DRAIN: begin
                    // Row counter wraps to 0 on the last handshake, ready for the next tile.
                    if (out_ready) begin
                        out_row_reg <= out_row_reg + 2'd1;
                        if (out_row_reg == 2'd3) begin
                            state_reg <= ST_LOAD;
                            mask_reg  <= '0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_LOAD;
            endcase
        end
    end

    assign out_valid = (state_reg == ST_DRAIN);
    assign busy      = (state_reg == ST_SETTLE) || (state_reg == ST_DRAIN);
    assign out_row   = out_row_reg;
    assign out_data  = d_reg[64*out_row_reg +: 64];
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: doc/fp8_tile_stager.md
# fp8_tile_stager

Sequential operand-staging and result-drain stage around the combinational FP8 4x4 tensor core (D = A×B + C, A/B FP8, C/D FP16). Accepts A, B and C one row per handshake into holding registers, holds them stable at the core's inputs while the core settles, captures D, then streams D out one row per handshake. It sits directly upstream of the core (feeding A/B/C) and directly downstream of it (consuming D). One tile in flight at a time.

## Interface
- SETTLE_CYCLES, default 1: cycles the operand registers are held stable before D is captured; legal range 1..15.
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  load beat valid
- in_ready  output  1  stager accepts load beats (high only in LOAD)
- in_sel  input  2  0 = A row, 1 = B row, 2 = C row, 3 = reserved (beat accepted, discarded, err pulsed)
- in_row  input  2  row index i
- in_data  input  64  A/B: element k at [8k+7:8k], [63:32] ignored; C: element k at [16k+15:16k]
- start  input  1  request compute; sampled only in LOAD
- a_flat  output  128  to core; A[i][j] at bits [(4i+j)*8 +: 8]
- b_flat  output  128  to core; B[i][j] at bits [(4i+j)*8 +: 8]
- c_flat  output  256  to core; C[i][j] at bits [(4i+j)*16 +: 16]
- d_flat  input  256  from core; D[i][j] at bits [(4i+j)*16 +: 16]
- out_valid  output  1  result row valid
- out_ready  input  1  consumer accepts result row
- out_row  output  2  row index of out_data
- out_data  output  64  D row; element j at [16j+15:16j]
- busy  output  1  high in SETTLE or DRAIN
- done  output  1  one-cycle pulse after the last row is drained
- err  output  1  one-cycle pulse on rejected start or in_sel = 3

## Operation
- States: LOAD, SETTLE, DRAIN.
- LOAD: in_ready = 1. Beat accepted when in_valid && in_ready; writes the selected row register and sets its bit in a 12-bit loaded mask (4 A, 4 B, 4 C). Rewriting a row overwrites it; the mask bit stays set.
- start in LOAD with the mask full (including a beat accepted in the same cycle) -> SETTLE, settle counter = 0. start with the mask incomplete -> ignored, err pulses next cycle, state stays LOAD.
- SETTLE: counter increments each cycle; on the cycle the counter equals SETTLE_CYCLES-1, the D register captures d_flat at that clock edge and the state goes to DRAIN, out_row = 0.
- DRAIN: out_valid = 1, out_data = D register row out_row. On out_valid && out_ready: row 3 -> LOAD, mask cleared to 0, done pulses; otherwise out_row increments.
- a_flat/b_flat/c_flat always reflect the operand registers, which are written only in LOAD, so they are stable throughout SETTLE and DRAIN.
- in_valid outside LOAD is not accepted (in_ready = 0); the source holds the beat. start outside LOAD is ignored and raises no err.
- No arithmetic in this block; values pass bit-exact.

## Timing
- Reset (async assert, sync-safe release): state LOAD, all operand/D registers 0, mask 0, in_ready 1, out_valid 0, out_row 0, out_data 0, busy 0, done 0, err 0. Reset mid-tile aborts it; the partial tile is lost.
- start accepted at edge T: busy = 1 from T; D captured at edge T+SETTLE_CYCLES; out_valid = 1 from that edge.
- With out_ready held high, rows drain on 4 consecutive cycles; done is high the cycle after the row-3 handshake, and in_ready is high in that same cycle.
- Minimum tile turnaround (12 load beats + start on the last beat): 12 + SETTLE_CYCLES + 4 cycles.
- out_data/out_row stay stable while out_valid && !out_ready.

## Test plan
- Reset: assert rst_n = 0 mid-DRAIN -> immediately out_valid = 0, in_ready = 1, busy = 0, all flats 0.
- Identity tile: A = I (0x3C on diagonal, E5M2 1.0), B = all 0x40 (2.0), C = 0; core stub returns d_flat = 0x4000 everywhere -> 4 rows of 0x4000_4000_4000_4000 on out_row 0..3, then done.
- Incomplete load: load A and B only, pulse start -> err pulses one cycle, busy stays 0; load C, start -> SETTLE entered.
- Back-pressure: out_ready toggling 1,0,0,1,… -> each row held stable while stalled; exactly 4 handshakes, rows in order 0..3.
- SETTLE_CYCLES = 3 with a stub core that changes d_flat 1 cycle after a_flat changes -> captured value is the post-change value; out_valid first high 3 edges after start.
- Same-cycle last beat and start: 12th beat (C row 3) with start asserted -> accepted, SETTLE entered next cycle; in_sel = 3 beat -> err pulse, mask unchanged.
